// File: rtl/wb_stage_buf_if.sv
// Write-back stage bus: MEM-side input, register-file write port,
// forwarding tap and occupancy.
interface wb_stage_buf_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 2,
    parameter int DEPTH  = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic              in_wr;
    logic              in_rm;
    logic [DATA_W-1:0] in_ac;
    logic [DATA_W-1:0] in_mem;
    logic [REG_AW-1:0] in_rd;
    logic [1:0]        in_lsz;
    logic              flush;
    logic              rf_ready;
    logic              wr_en;
    logic [REG_AW-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_addr;
    logic [DATA_W-1:0] fwd_data;
    logic [CW-1:0]     count;

    modport slave (
        input  in_valid, in_wr, in_rm, in_ac, in_mem, in_rd, in_lsz,
        input  flush, rf_ready,
        output in_ready, wr_en, wr_addr, wr_data,
        output fwd_valid, fwd_addr, fwd_data, count
    );

    modport master (
        output in_valid, in_wr, in_rm, in_ac, in_mem, in_rd, in_lsz,
        output flush, rf_ready,
        input  in_ready, wr_en, wr_addr, wr_data,
        input  fwd_valid, fwd_addr, fwd_data, count
    );
endinterface

// File: rtl/wb_stage_buf.sv
// Write-back stage: ALU/memory result select feeding a small register-write queue.
// Optional load-size extension is enabled with `define WB_LOAD_EXT_EN.
module wb_stage_buf #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 2,
    parameter int DEPTH  = 2
) (
    input  logic            clk,
    input  logic            reset,
    wb_stage_buf_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic              not_empty;
    logic              in_ready;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] ext_mem;
    logic [DATA_W-1:0] res;
    entry_t            head;
    entry_t            tail;
    logic [PW-1:0]     tail_ptr;

`ifdef WB_LOAD_EXT_EN
    always_comb begin
        ext_mem = bus.in_mem;
        unique case (bus.in_lsz)
            2'b01:   ext_mem = {{(DATA_W-8){1'b0}}, bus.in_mem[7:0]};
            2'b10:   ext_mem = {{(DATA_W-8){bus.in_mem[7]}}, bus.in_mem[7:0]};
            default: ext_mem = bus.in_mem;
        endcase
    end
`else
    logic unused_lsz;
    assign unused_lsz = ^bus.in_lsz;
    assign ext_mem    = bus.in_mem;
`endif

    assign res       = bus.in_rm ? ext_mem : bus.in_ac;
    assign not_empty = (count_q != '0);
    assign in_ready  = (count_q != CW'(DEPTH));
    assign push      = bus.in_valid & in_ready & bus.in_wr & ~bus.flush;
    assign pop       = not_empty & bus.rf_ready & ~bus.flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{rd: bus.in_rd, data: res};
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never cleared; outputs are masked while empty instead.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign tail_ptr = wr_ptr_q - PW'(1);
    assign head     = mem_q[rd_ptr_q];
    assign tail     = mem_q[tail_ptr];

    assign bus.in_ready  = in_ready;
    assign bus.count     = count_q;
    assign bus.wr_en     = not_empty;
    assign bus.wr_addr   = not_empty ? head.rd   : '0;
    assign bus.wr_data   = not_empty ? head.data : '0;
    assign bus.fwd_valid = not_empty;
    assign bus.fwd_addr  = not_empty ? tail.rd   : '0;
    assign bus.fwd_data  = not_empty ? tail.data : '0;
endmodule

// File: tb/tb_wb_stage_buf.sv
// Randomised and directed bench for wb_stage_buf against a queue-based model.
module tb_wb_stage_buf;
    localparam int DW    = 16;
    localparam int AW    = 2;
    localparam int DEPTH = 2;

    typedef struct {
        int rd;
        int data;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    int   errs   = 0;
    int   checks = 0;
    ent_t q[$];
    int   mcommit[$];
    int   dcommit[$];

    always #5 clk = ~clk;

    wb_stage_buf_if #(.DATA_W(DW), .REG_AW(AW), .DEPTH(DEPTH)) bus ();

    wb_stage_buf #(.DATA_W(DW), .REG_AW(AW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int ext_ref(input int mem, input int lsz);
        int b;
        b = mem % 256;
`ifdef WB_LOAD_EXT_EN
        if (lsz == 1) return b;
        if (lsz == 2) return (b < 128) ? b : b + 'hFF00;
`endif
        return mem;
    endfunction

    task automatic drive(input bit v, input bit wr, input bit rm,
                         input int ac, input int mem, input int rd,
                         input int lsz, input bit fl, input bit rr);
        bus.in_valid = v;
        bus.in_wr    = wr;
        bus.in_rm    = rm;
        bus.in_ac    = DW'(ac);
        bus.in_mem   = DW'(mem);
        bus.in_rd    = AW'(rd);
        bus.in_lsz   = 2'(lsz);
        bus.flush    = fl;
        bus.rf_ready = rr;
    endtask

    task automatic check_outs();
        int n;
        n = q.size();
        chk("count", 32'(bus.count), n);
        chk("in_ready", 32'(bus.in_ready), 32'(n != DEPTH));
        chk("wr_en", 32'(bus.wr_en), 32'(n != 0));
        chk("fwd_valid", 32'(bus.fwd_valid), 32'(n != 0));
        chk("wr_addr", 32'(bus.wr_addr), n != 0 ? q[0].rd : 0);
        chk("wr_data", 32'(bus.wr_data), n != 0 ? q[0].data : 0);
        chk("fwd_addr", 32'(bus.fwd_addr), n != 0 ? q[n-1].rd : 0);
        chk("fwd_data", 32'(bus.fwd_data), n != 0 ? q[n-1].data : 0);
    endtask

    task automatic step();
        ent_t nq[$];
        int   res;
        nq  = q;
        res = bus.in_rm ? ext_ref(int'(bus.in_mem), int'(bus.in_lsz))
                        : int'(bus.in_ac);
        if (reset || bus.flush) begin
            nq.delete();
        end else begin
            if (q.size() != 0 && bus.rf_ready) begin
                mcommit.push_back(q[0].data);
                dcommit.push_back(int'(bus.wr_data));
                void'(nq.pop_front());
            end
            if (bus.in_valid && q.size() != DEPTH && bus.in_wr)
                nq.push_back('{int'(bus.in_rd), res});
        end
        @(posedge clk);
        #1;
        q = nq;
        check_outs();
    endtask

    initial begin
        int lszs[3];
        int ext_exp[3];
        int d;
        lszs = '{1, 2, 0};
`ifdef WB_LOAD_EXT_EN
        ext_exp = '{'h0080, 'hFF80, 'h1280};
`else
        ext_exp = '{'h1280, 'h1280, 'h1280};
`endif
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        reset = 1'b0;

        // Basic push, one-cycle latency
        drive(1, 1, 0, 'h1234, 0, 2, 0, 0, 1);
        step();
        chk("t1_data", 32'(bus.wr_data), 'h1234);
        chk("t1_addr", 32'(bus.wr_addr), 2);

        // Fill while stalled, then drain in order
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        drive(1, 1, 0, 'hAAAA, 0, 1, 0, 0, 0);
        step();
        drive(1, 1, 0, 'hBBBB, 0, 3, 0, 0, 0);
        step();
        chk("t2_full", 32'(bus.in_ready), 0);
        chk("t2_head", 32'(bus.wr_data), 'hAAAA);
        chk("t2_fwd", 32'(bus.fwd_data), 'hBBBB);
        mcommit.delete();
        dcommit.delete();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        chk("t2_ready", 32'(bus.in_ready), 1);
        step();
        chk("t2_ncommit", dcommit.size(), 2);
        if (dcommit.size() == 2) begin
            chk("t2_c0", dcommit[0], 'hAAAA);
            chk("t2_c1", dcommit[1], 'hBBBB);
        end

        // Simultaneous push/pop across pointer wrap
        drive(1, 1, 0, 'h0F0F, 0, 1, 0, 0, 1);
        step();
        for (int i = 0; i < 5; i++) begin
            d = 'h0F0F + (i + 1) * 'h1111;
            drive(1, 1, 0, d, 0, i % 4, 0, 0, 1);
            step();
            chk("t3_count", 32'(bus.count), 1);
            chk("t3_head", 32'(bus.wr_data), d % 'h10000);
        end

        // Flush with a full queue and a pending push
        drive(1, 1, 0, 'h5555, 0, 2, 0, 0, 0);
        step();
        drive(1, 1, 0, 'h6666, 0, 3, 0, 0, 0);
        step();
        mcommit.delete();
        dcommit.delete();
        drive(1, 1, 0, 'h7777, 0, 1, 0, 0, 0);
        step();
        chk("t4_full", 32'(bus.count), 2);
        drive(1, 1, 0, 'h7777, 0, 1, 0, 1, 1);
        step();
        chk("t4_flush", 32'(bus.count), 0);
        chk("t4_wr_en", 32'(bus.wr_en), 0);
        chk("t4_nocommit", dcommit.size(), 0);
        drive(1, 0, 0, 'h8888, 0, 1, 0, 0, 0);
        step();
        chk("t4_nowr", 32'(bus.count), 0);
        drive(1, 1, 0, 'h9999, 0, 1, 0, 0, 0);
        step();
        drive(1, 0, 0, 'hABCD, 0, 2, 0, 0, 0);
        step();
        chk("t4_nowr1", 32'(bus.count), 1);

        // Load-size extension
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 'h4321, 'h1280, 0, lszs[i], 0, 1);
            step();
            chk("t5_ext", 32'(bus.wr_data), ext_exp[i]);
        end

        // Reset beats flush
        drive(1, 1, 0, 'h1111, 0, 1, 0, 0, 0);
        step();
        drive(1, 1, 0, 'h2222, 0, 2, 0, 0, 0);
        step();
        drive(1, 1, 0, 'h3333, 0, 3, 0, 1, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_count", 32'(bus.count), 0);
        chk("t6_ready", 32'(bus.in_ready), 1);
        chk("t6_data", 32'(bus.wr_data), 0);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(3) != 0, $urandom_range(7) != 0,
                  $urandom_range(1) == 1, int'($urandom_range(16'hFFFF)),
                  int'($urandom_range(16'hFFFF)), int'($urandom_range(3)),
                  int'($urandom_range(3)), $urandom_range(15) == 0,
                  $urandom_range(1) == 1);
            reset = ($urandom_range(63) == 0);
            step();
        end
        reset = 1'b0;

        chk("commit_n", dcommit.size(), mcommit.size());
        for (int i = 0; i < dcommit.size() && i < mcommit.size(); i++) begin
            if (dcommit[i] != mcommit[i])
                chk("commit", dcommit[i], mcommit[i]);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
